// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_pkg
// Purpose  : Shared types and constants for the data-memory arbiter slice:
//            bus widths, owner tag, request bundle, FSM state encodings and
//            a saturating counter helper.
// Revision : 1.0  initial release
// ============================================================================
package dmem_arbiter_pkg;

    localparam int XLEN = 32;
    localparam int ALEN = 32;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } dmem_owner_e;

    typedef struct packed {
        logic [ALEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic            we;
        logic [3:0]      be;
        logic [2:0]      funct3;
    } dmem_req_t;

    // One entry of the read-response tag pipe
    typedef struct packed {
        logic        valid;
        dmem_owner_e owner;
    } rsp_tag_t;

    // Arbiter FSM encoding
    localparam logic [0:0] S_NORMAL = 1'b0;
    localparam logic [0:0] S_FORCE  = 1'b1;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Purpose  : Bundles the CPU port (c_*), DMA port (d_*) and memory port
//            (mem_*) of the data-memory arbiter.
//            slave  : arbiter view (requests/mem_rdata in, grants/mem out)
//            master : environment view (the mirror image)
// Revision : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic            c_req;
    logic [ALEN-1:0] c_addr;
    logic [XLEN-1:0] c_wdata;
    logic            c_we;
    logic [3:0]      c_be;
    logic [2:0]      c_funct3;
    logic            c_stall;
    logic            c_rvalid;

    logic            d_req;
    logic [ALEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_we;
    logic [3:0]      d_be;
    logic [2:0]      d_funct3;
    logic            d_gnt;
    logic            d_rvalid;

    logic [ALEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_we;
    logic [3:0]      mem_be;
    logic [2:0]      mem_funct3;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] rdata;

    modport slave (
        input  c_req, c_addr, c_wdata, c_we, c_be, c_funct3,
        input  d_req, d_addr, d_wdata, d_we, d_be, d_funct3,
        input  mem_rdata,
        output c_stall, c_rvalid, d_gnt, d_rvalid,
        output mem_addr, mem_wdata, mem_we, mem_be, mem_funct3, rdata
    );

    modport master (
        output c_req, c_addr, c_wdata, c_we, c_be, c_funct3,
        output d_req, d_addr, d_wdata, d_we, d_be, d_funct3,
        output mem_rdata,
        input  c_stall, c_rvalid, d_gnt, d_rvalid,
        input  mem_addr, mem_wdata, mem_we, mem_be, mem_funct3, rdata
    );

endinterface
`default_nettype wire

// File: rtl/dmem_rsp_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dmem_rsp_tag_pipe
// Purpose  : RD_LAT-deep shift register of {valid, owner} tags that follows
//            each memory read so its data can be routed back to the issuer.
// Ports    : clk, rst_n (async active-low clear)
//            push : tag entering stage 0 on every clock
//            head : tag leaving the last stage (aligned with mem_rdata)
// Revision : 1.0  initial release
// ============================================================================
module dmem_rsp_tag_pipe
    import dmem_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  rsp_tag_t push,
    output rsp_tag_t head
);

    rsp_tag_t stage_q [RD_LAT];
    rsp_tag_t stage_d [RD_LAT];

    always_comb begin
        stage_d[0] = push;
        for (int i = 1; i < RD_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    for (genvar g = 0; g < RD_LAT; g++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_q[g] <= '0;
            end else begin
                stage_q[g] <= stage_d[g];
            end
        end
    end

    assign head = stage_q[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one data-memory port between the CPU MEM stage (port C,
//            fixed priority) and a DMA/debug master (port D). After
//            STARVE_LIMIT consecutive denied D cycles, D is forced through
//            for one cycle and the CPU stalls. Read responses are steered to
//            their issuer by an owner-tag pipe RD_LAT stages deep.
// Ports    : clk, rst_n (async active-low)
//            bus : dmem_arbiter_if.slave (c_*, d_*, mem_*, rdata)
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,   // 1..255
    parameter int RD_LAT       = 1    // 1..4
) (
    input  logic         clk,
    input  logic         rst_n,
    dmem_arbiter_if.slave bus
);

    localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);

    logic [0:0] state_q, state_d;
    logic [7:0] starve_q, starve_d;

    dmem_req_t c_fld, d_fld, sel;
    logic      force_grant;
    logic      c_gnt, d_gnt;
    rsp_tag_t  push_tag, head_tag;

    always_comb begin
        c_fld = '{addr: bus.c_addr, wdata: bus.c_wdata, we: bus.c_we,
                  be: bus.c_be, funct3: bus.c_funct3};
        d_fld = '{addr: bus.d_addr, wdata: bus.d_wdata, we: bus.d_we,
                  be: bus.d_be, funct3: bus.d_funct3};

        // A forced cycle only overrides C if D is still asking; otherwise
        // C keeps its normal priority.
        force_grant = (state_q == S_FORCE) && bus.d_req;
        c_gnt       = bus.c_req && !force_grant;
        d_gnt       = bus.d_req && (force_grant || !bus.c_req);

        // With no grant the C fields still drive the bus; mem_we masks it.
        sel = d_gnt ? d_fld : c_fld;

        push_tag.valid = (c_gnt || d_gnt) && !sel.we;
        push_tag.owner = d_gnt ? OWN_DMA : OWN_CPU;

        starve_d = (bus.d_req && !d_gnt) ? sat_inc(starve_q) : 8'd0;

        // S_FORCE lasts exactly one cycle whatever happens in it.
        state_d = S_NORMAL;
        if ((state_q == S_NORMAL) && bus.d_req && !d_gnt && (starve_q == LIMIT_M1)) begin
            state_d = S_FORCE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_NORMAL;
            starve_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    dmem_rsp_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_tag),
        .head  (head_tag)
    );

    // Handshake outputs are forced quiet while reset is held, even though
    // the request inputs may still be active.
    assign bus.c_stall    = rst_n && bus.c_req && !c_gnt;
    assign bus.d_gnt      = rst_n && d_gnt;
    assign bus.mem_we     = rst_n && sel.we && (c_gnt || d_gnt);
    assign bus.mem_addr   = sel.addr;
    assign bus.mem_wdata  = sel.wdata;
    assign bus.mem_be     = sel.be;
    assign bus.mem_funct3 = sel.funct3;

    assign bus.c_rvalid   = head_tag.valid && (head_tag.owner == OWN_CPU);
    assign bus.d_rvalid   = head_tag.valid && (head_tag.owner == OWN_DMA);
    assign bus.rdata      = bus.mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter with a transaction-level
//            reference model (lost-cycle count, response queue) and a
//            latency-RD_LAT memory whose contents are a hash of the address.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int LIMIT = 8;
    localparam int LAT   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();

    dmem_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .RD_LAT       (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC3A5_0F1E;
    endfunction

    // Memory: returns memfn(addr) LAT cycles after the address is presented
    logic [31:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= bus.mem_addr;
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign bus.mem_rdata = memfn(apipe[LAT-1]);

    // Reference model state
    typedef struct {
        logic        own;   // 0 = CPU, 1 = DMA
        logic [31:0] addr;
        int          due;
    } rsp_t;

    rsp_t q[$];
    int   lost;
    bit   force_now;
    int   cyc;
    logic e_cg, e_dg, e_crv, e_drv;
    logic [31:0] e_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic drive(input logic cr, input logic [31:0] ca, input logic cw,
                         input logic dr, input logic [31:0] da, input logic dw,
                         input logic [3:0] dbe);
        bus.c_req = cr; bus.c_addr = ca; bus.c_we = cw; bus.c_wdata = $urandom;
        bus.c_be = 4'hF; bus.c_funct3 = 3'b010;
        bus.d_req = dr; bus.d_addr = da; bus.d_we = dw; bus.d_wdata = $urandom;
        bus.d_be = dbe; bus.d_funct3 = 3'b010;
    endtask

    task automatic drive_idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'hF);
    endtask

    // Move to the sampling point of the current cycle and compute what the
    // arbiter should be doing from the model state.
    task automatic eval();
        rsp_t r;
        @(negedge clk);
        if (force_now && bus.d_req) begin
            e_dg = 1'b1; e_cg = 1'b0;
        end else begin
            e_cg = bus.c_req; e_dg = !bus.c_req && bus.d_req;
        end
        e_crv = 1'b0; e_drv = 1'b0; e_rdata = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            e_crv = !r.own; e_drv = r.own; e_rdata = memfn(r.addr);
        end
    endtask

    // Record issued reads, update the lost-cycle count, cross the clock edge
    task automatic commit();
        if (e_cg && !bus.c_we) q.push_back('{1'b0, bus.c_addr, cyc + LAT});
        if (e_dg && !bus.d_we) q.push_back('{1'b1, bus.d_addr, cyc + LAT});
        if (bus.d_req && !e_dg) lost++;
        else lost = 0;
        force_now = (lost == LIMIT);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        q.delete();
        lost = 0;
        force_now = 1'b0;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            drive_idle();
            eval();
            n_tests++;
            if (bus.c_rvalid !== e_crv) begin
                n_fail++; $display("FAIL quiet_c_rvalid got=%b exp=%b", bus.c_rvalid, e_crv);
            end
            n_tests++;
            if (bus.d_rvalid !== e_drv) begin
                n_fail++; $display("FAIL quiet_d_rvalid got=%b exp=%b", bus.d_rvalid, e_drv);
            end
            if (e_crv || e_drv) begin
                n_tests++;
                if (bus.rdata !== e_rdata) begin
                    n_fail++; $display("FAIL quiet_rdata got=%h exp=%h", bus.rdata, e_rdata);
                end
            end
            commit();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 32'h4, 1'b1, 1'b1, 32'h8, 1'b1, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.c_stall, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.mem_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got={stall,dgnt,crv,drv,we}=%b exp=00000",
                     {bus.c_stall, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.mem_we});
        end
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        model_reset();
    endtask

    task automatic test_starve();
        for (int i = 0; i < 18; i++) begin
            bit exp;
            exp = (i % 9 == 8);
            drive(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b1, 32'h200, 1'b0, 4'hF);
            eval();
            n_tests++;
            if (bus.d_gnt !== exp) begin
                n_fail++; $display("FAIL starve_d_gnt cyc=%0d got=%b exp=%b", i, bus.d_gnt, exp);
            end
            n_tests++;
            if (bus.c_stall !== exp) begin
                n_fail++; $display("FAIL starve_c_stall cyc=%0d got=%b exp=%b", i, bus.c_stall, exp);
            end
            commit();
        end
    endtask

    task automatic test_d_read();
        quiet(LAT + 1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0, 4'hF);
        eval();
        n_tests++;
        if (bus.d_gnt !== 1'b1 || bus.mem_addr !== 32'h40) begin
            n_fail++; $display("FAIL d_read_issue got gnt=%b addr=%h exp gnt=1 addr=00000040",
                               bus.d_gnt, bus.mem_addr);
        end
        commit();
        for (int k = 1; k <= LAT + 1; k++) begin
            drive_idle();
            eval();
            n_tests++;
            if (bus.d_rvalid !== (k == LAT) || bus.c_rvalid !== 1'b0) begin
                n_fail++; $display("FAIL d_read_rvalid k=%0d got d=%b c=%b exp d=%b c=0",
                                   k, bus.d_rvalid, bus.c_rvalid, (k == LAT));
            end
            if (k == LAT) begin
                n_tests++;
                if (bus.rdata !== memfn(32'h40)) begin
                    n_fail++; $display("FAIL d_read_rdata got=%h exp=%h", bus.rdata, memfn(32'h40));
                end
            end
            commit();
        end
    endtask

    task automatic test_back_to_back();
        logic        own [3];
        logic [31:0] adr [3];
        own[0] = 1'b0; adr[0] = 32'h10;
        own[1] = 1'b1; adr[1] = 32'h20;
        own[2] = 1'b0; adr[2] = 32'h30;
        quiet(LAT + 1);
        for (int k = 0; k < LAT + 4; k++) begin
            int j;
            j = k - LAT;
            if (k < 3) drive(!own[k], adr[k], 1'b0, own[k], adr[k], 1'b0, 4'hF);
            else       drive_idle();
            eval();
            if (j >= 0 && j < 3) begin
                n_tests++;
                if (bus.c_rvalid !== !own[j] || bus.d_rvalid !== own[j] || bus.rdata !== memfn(adr[j])) begin
                    n_fail++; $display("FAIL b2b_rsp%0d got c=%b d=%b data=%h exp c=%b d=%b data=%h",
                                       j, bus.c_rvalid, bus.d_rvalid, bus.rdata,
                                       !own[j], own[j], memfn(adr[j]));
                end
            end else begin
                n_tests++;
                if (bus.c_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_bubble k=%0d got c=%b d=%b exp 0 0",
                                       k, bus.c_rvalid, bus.d_rvalid);
                end
            end
            commit();
        end
    endtask

    task automatic test_d_store();
        quiet(LAT + 1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h80, 1'b1, 4'b0011);
        eval();
        n_tests++;
        if (bus.d_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_be !== 4'b0011
            || bus.mem_addr !== 32'h80) begin
            n_fail++; $display("FAIL d_store got gnt=%b we=%b be=%b addr=%h exp 1 1 0011 00000080",
                               bus.d_gnt, bus.mem_we, bus.mem_be, bus.mem_addr);
        end
        commit();
        for (int k = 0; k < LAT + 1; k++) begin
            drive_idle();
            eval();
            n_tests++;
            if (bus.c_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
                n_fail++; $display("FAIL d_store_rvalid got c=%b d=%b exp 0 0", bus.c_rvalid, bus.d_rvalid);
            end
            commit();
        end
    endtask

    task automatic test_force_drop();
        quiet(LAT + 1);
        for (int i = 0; i < LIMIT; i++) begin
            drive(1'b1, 32'h300, 1'b0, 1'b1, 32'h400, 1'b0, 4'hF);
            eval();
            commit();
        end
        // forced cycle, but D has withdrawn
        drive(1'b1, 32'h304, 1'b0, 1'b0, 32'h400, 1'b0, 4'hF);
        eval();
        n_tests++;
        if (bus.c_stall !== 1'b0 || bus.d_gnt !== 1'b0) begin
            n_fail++; $display("FAIL force_drop got stall=%b dgnt=%b exp 0 0", bus.c_stall, bus.d_gnt);
        end
        commit();
        // counter restarted: D must lose another full LIMIT cycles
        for (int i = 0; i <= LIMIT; i++) begin
            drive(1'b1, 32'h308, 1'b0, 1'b1, 32'h404, 1'b0, 4'hF);
            eval();
            n_tests++;
            if (bus.d_gnt !== (i == LIMIT)) begin
                n_fail++; $display("FAIL force_drop_recount i=%0d got=%b exp=%b", i, bus.d_gnt, (i == LIMIT));
            end
            commit();
        end
    endtask

    task automatic test_reset_inflight();
        quiet(LAT + 1);
        // builds up a pending forced grant and leaves C reads in flight
        for (int i = 0; i < LIMIT; i++) begin
            drive(1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b1, 32'h600, 1'b0, 4'hF);
            eval();
            commit();
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.c_stall, bus.d_gnt, bus.c_rvalid, bus.d_rvalid} !== 4'b0) begin
            n_fail++; $display("FAIL reset_mid got={stall,dgnt,crv,drv}=%b exp=0000",
                               {bus.c_stall, bus.d_gnt, bus.c_rvalid, bus.d_rvalid});
        end
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        model_reset();
        drive(1'b1, 32'h700, 1'b0, 1'b1, 32'h800, 1'b0, 4'hF);
        eval();
        n_tests++;
        if (bus.c_stall !== 1'b0 || bus.d_gnt !== 1'b0 || bus.c_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release got stall=%b dgnt=%b crv=%b drv=%b exp 0 0 0 0",
                               bus.c_stall, bus.d_gnt, bus.c_rvalid, bus.d_rvalid);
        end
        commit();
        quiet(LAT + 2);
    endtask

    task automatic test_random();
        quiet(LAT + 1);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] exp_addr;
            logic        exp_we;
            drive($urandom_range(0, 9) < 8, {$urandom_range(0, 255), 2'b00}, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) < 7, {$urandom_range(256, 511), 2'b00}, $urandom_range(0, 3) == 0,
                  4'($urandom));
            eval();
            exp_addr = e_dg ? bus.d_addr : bus.c_addr;
            exp_we   = (e_cg && bus.c_we) || (e_dg && bus.d_we);
            n_tests++;
            if (bus.d_gnt !== e_dg || bus.c_stall !== (bus.c_req && !e_cg)) begin
                n_fail++; $display("FAIL rand_grant i=%0d got dgnt=%b stall=%b exp %b %b",
                                   i, bus.d_gnt, bus.c_stall, e_dg, (bus.c_req && !e_cg));
            end
            n_tests++;
            if (bus.mem_we !== exp_we || bus.mem_addr !== exp_addr) begin
                n_fail++; $display("FAIL rand_mem i=%0d got we=%b addr=%h exp %b %h",
                                   i, bus.mem_we, bus.mem_addr, exp_we, exp_addr);
            end
            n_tests++;
            if (bus.c_rvalid !== e_crv || bus.d_rvalid !== e_drv) begin
                n_fail++; $display("FAIL rand_rvalid i=%0d got c=%b d=%b exp %b %b",
                                   i, bus.c_rvalid, bus.d_rvalid, e_crv, e_drv);
            end
            if (e_crv || e_drv) begin
                n_tests++;
                if (bus.rdata !== e_rdata) begin
                    n_fail++; $display("FAIL rand_rdata i=%0d got=%h exp=%h", i, bus.rdata, e_rdata);
                end
            end
            commit();
        end
        quiet(LAT + 1);
    endtask

    initial begin
        cyc = 0;
        model_reset();
        test_reset();
        test_starve();
        test_d_read();
        test_back_to_back();
        test_d_store();
        test_force_drop();
        test_reset_inflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
